// File: rtl/core_pipe_lsu_rsp.sv
// ---------------------------------------------------------------------------
// core_pipe_lsu_rsp
//
// Data-memory response stage that sits directly behind the execute-stage LSU
// request logic. It records the attributes of each granted load/store, picks
// up the fixed-latency memory response one cycle after the grant, aligns and
// extends load data, and holds the result for writeback under a valid/ready
// handshake. Only one transaction may be outstanding at a time.
//
// Optional feature macro: CORE_LSU_RSP_BYPASS_EN
//   When defined, the response is forwarded combinationally to writeback in
//   the cycle it arrives, and the HOLD register is used only if writeback
//   stalls. When undefined, every wb_* output comes straight from a register.
//
// Ports:
//   g_clk, g_resetn       clock, synchronous active-low reset
//   flush                 discard pending and held responses
//   req_sent              request granted this cycle
//   req_load/req_store    kind of the granted request
//   req_double/word/half/byte  access size (one-hot)
//   req_sext              sign-extend load data
//   req_addr_lo           addr[2:0] of the granted request
//   dmem_err/dmem_rdata   memory response, valid the cycle after grant
//   rsp_can_issue         LSU may have a request granted this cycle
//   wb_valid/wb_ready     writeback handshake
//   wb_load/wb_err        attributes of the presented response
//   wb_rdata              aligned, extended load data (0 for stores)
//
// XLEN and MEM_DATA_W must both be 64: the 3-bit byte offset spans exactly
// one 64-bit memory word.
// ---------------------------------------------------------------------------
module core_pipe_lsu_rsp #(
   parameter int XLEN       = 64,
   parameter int MEM_DATA_W = 64
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   input  logic                  flush,
   input  logic                  req_sent,
   input  logic                  req_load,
   input  logic                  req_store,
   input  logic                  req_double,
   input  logic                  req_word,
   input  logic                  req_half,
   input  logic                  req_byte,
   input  logic                  req_sext,
   input  logic [2:0]            req_addr_lo,
   input  logic                  dmem_err,
   input  logic [MEM_DATA_W-1:0] dmem_rdata,
   output logic                  rsp_can_issue,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic                  wb_load,
   output logic                  wb_err,
   output logic [XLEN-1:0]       wb_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } state_t;

   state_t state_q, state_d;

   logic           load_q, store_q, sext_q;
   logic           dbl_q, word_q, half_q, byte_q;
   logic [2:0]     addr_q;

   logic           wb_valid_q, wb_load_q, wb_err_q;
   logic [XLEN-1:0] wb_rdata_q;

   logic [MEM_DATA_W-1:0] shifted;
   logic [XLEN-1:0]       aligned;
   logic [XLEN-1:0]       respData;
   logic                  liveRsp;

   // The LSU may issue whenever no unflushed response is due this cycle and
   // any held result is leaving. DROP is free because its response (if any)
   // is thrown away.
   assign rsp_can_issue = (state_q == ST_IDLE) ||
                          ((state_q == ST_HOLD) && wb_ready) ||
                          (state_q == ST_DROP);

   // A live response is one arriving in WAIT that is not being flushed.
   assign liveRsp = (state_q == ST_WAIT) && !flush;

   // Move the addressed byte lane down to bit 0, then select the field for
   // the captured size and extend it. A request flagged as both load and
   // store is treated as a store, so it never returns data.
   always_comb begin
      shifted  = dmem_rdata >> {addr_q, 3'b000};
      aligned  = '0;
      if (dbl_q) begin
         aligned = shifted[XLEN-1:0];
      end else if (word_q) begin
         aligned = {{(XLEN-32){sext_q & shifted[31]}}, shifted[31:0]};
      end else if (half_q) begin
         aligned = {{(XLEN-16){sext_q & shifted[15]}}, shifted[15:0]};
      end else if (byte_q) begin
         aligned = {{(XLEN-8){sext_q & shifted[7]}}, shifted[7:0]};
      end
      respData = (load_q && !store_q) ? aligned : '0;
   end

   // Next-state selection. Flush wins over everything; a grant that
   // coincides with a flush still produces a response one cycle later, so it
   // is steered into DROP where that response is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_sent) state_d = flush ? ST_DROP : ST_WAIT;
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = ST_DROP;
            end else begin
`ifdef CORE_LSU_RSP_BYPASS_EN
               state_d = wb_ready ? ST_IDLE : ST_HOLD;
`else
               state_d = ST_HOLD;
`endif
            end
         end
         ST_HOLD: begin
            if (flush) begin
               state_d = req_sent ? ST_DROP : ST_IDLE;
            end else if (wb_ready) begin
               state_d = req_sent ? ST_WAIT : ST_IDLE;
            end
         end
         ST_DROP: begin
            if (req_sent) state_d = flush ? ST_DROP : ST_WAIT;
            else          state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, request attributes and the writeback register. The result
   // register is only loaded in WAIT, so it stays stable throughout HOLD.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q    <= ST_IDLE;
         load_q     <= 1'b0;
         store_q    <= 1'b0;
         sext_q     <= 1'b0;
         dbl_q      <= 1'b0;
         word_q     <= 1'b0;
         half_q     <= 1'b0;
         byte_q     <= 1'b0;
         addr_q     <= 3'b000;
         wb_valid_q <= 1'b0;
         wb_load_q  <= 1'b0;
         wb_err_q   <= 1'b0;
         wb_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= (state_d == ST_HOLD);
         if (req_sent) begin
            load_q  <= req_load;
            store_q <= req_store;
            sext_q  <= req_sext;
            dbl_q   <= req_double;
            word_q  <= req_word;
            half_q  <= req_half;
            byte_q  <= req_byte;
            addr_q  <= req_addr_lo;
         end
         if (state_q == ST_WAIT) begin
            wb_rdata_q <= respData;
            wb_err_q   <= dmem_err;
            wb_load_q  <= load_q;
         end
      end
   end

   // Writeback outputs: registered copy, or the live response when bypass
   // forwarding is built in.
`ifdef CORE_LSU_RSP_BYPASS_EN
   assign wb_valid = wb_valid_q | liveRsp;
   assign wb_load  = liveRsp ? load_q   : wb_load_q;
   assign wb_err   = liveRsp ? dmem_err : wb_err_q;
   assign wb_rdata = liveRsp ? respData : wb_rdata_q;
`else
   logic unusedLive;
   assign unusedLive = liveRsp;
   assign wb_valid   = wb_valid_q;
   assign wb_load    = wb_load_q;
   assign wb_err     = wb_err_q;
   assign wb_rdata   = wb_rdata_q;
`endif

endmodule

// File: tb/tb_core_pipe_lsu_rsp.sv
// ---------------------------------------------------------------------------
// tb_core_pipe_lsu_rsp
//
// Drives core_pipe_lsu_rsp with a few directed sequences followed by
// randomized traffic, and compares its outputs every cycle against a
// transaction-level model: "a response is due this cycle" plus "a result is
// being held for writeback".
// ---------------------------------------------------------------------------
module tb_core_pipe_lsu_rsp;

`ifdef CORE_LSU_RSP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        g_clk;
   logic        g_resetn;
   logic        flush;
   logic        req_sent;
   logic        req_load;
   logic        req_store;
   logic        req_double;
   logic        req_word;
   logic        req_half;
   logic        req_byte;
   logic        req_sext;
   logic [2:0]  req_addr_lo;
   logic        dmem_err;
   logic [63:0] dmem_rdata;
   logic        rsp_can_issue;
   logic        wb_valid;
   logic        wb_ready;
   logic        wb_load;
   logic        wb_err;
   logic [63:0] wb_rdata;

   int checks = 0;
   int errors = 0;

   // Model state
   bit          mValid = 0;
   bit          mPend, mPendDrop, mPLoad, mPSext;
   int          mPBytes;
   logic [2:0]  mPAddr;
   bit          mHeld, mHLoad, mHErr;
   logic [63:0] mHData;

   core_pipe_lsu_rsp #(.XLEN(64), .MEM_DATA_W(64)) dut (
      .g_clk        (g_clk),
      .g_resetn     (g_resetn),
      .flush        (flush),
      .req_sent     (req_sent),
      .req_load     (req_load),
      .req_store    (req_store),
      .req_double   (req_double),
      .req_word     (req_word),
      .req_half     (req_half),
      .req_byte     (req_byte),
      .req_sext     (req_sext),
      .req_addr_lo  (req_addr_lo),
      .dmem_err     (dmem_err),
      .dmem_rdata   (dmem_rdata),
      .rsp_can_issue(rsp_can_issue),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_load      (wb_load),
      .wb_err       (wb_err),
      .wb_rdata     (wb_rdata)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // Load result from first principles: drop addr bytes, keep the access
   // width, optionally fill the upper part with the field's top bit.
   function automatic logic [63:0] alignRef(input logic [63:0] rd, input logic [2:0] addr,
                                            input int bytes, input bit sext);
      logic [63:0] sh, mask, f;
      sh   = rd >> (int'(addr) * 8);
      mask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (bytes * 8)) - 64'd1);
      f    = sh & mask;
      if (sext && bytes < 8 && f[bytes*8-1]) f = f | ~mask;
      return f;
   endfunction

   function automatic bit modelLive();
      return mPend && !mPendDrop && !flush;
   endfunction

   function automatic bit modelCanIssue(input bit rdy);
      return !(mPend && !mPendDrop) && (!mHeld || rdy);
   endfunction

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of all outputs against the model.
   task automatic checkOutput();
      bit          expValid, live;
      logic [63:0] expData;
      bit          expLoad, expErr;
      if (!mValid) return;
      live     = modelLive();
      expValid = mHeld || (BYP && live);
      checkValue("can_issue", {63'd0, rsp_can_issue}, {63'd0, modelCanIssue(wb_ready)});
      checkValue("wb_valid", {63'd0, wb_valid}, {63'd0, expValid});
      if (expValid) begin
         if (mHeld) begin
            expData = mHData; expLoad = mHLoad; expErr = mHErr;
         end else begin
            expData = mPLoad ? alignRef(dmem_rdata, mPAddr, mPBytes, mPSext) : 64'd0;
            expLoad = mPLoad; expErr = dmem_err;
         end
         checkValue("wb_rdata", wb_rdata, expData);
         checkValue("wb_load", {63'd0, wb_load}, {63'd0, expLoad});
         checkValue("wb_err", {63'd0, wb_err}, {63'd0, expErr});
      end
   endtask

   // Advance the model across the coming clock edge using current inputs.
   task automatic modelStep();
      bit nextHeld;
      if (!g_resetn) begin
         mValid = 1; mPend = 0; mPendDrop = 0; mHeld = 0;
         mPLoad = 0; mPSext = 0; mPBytes = 8; mPAddr = 0;
         mHLoad = 0; mHErr = 0; mHData = 0;
         return;
      end
      nextHeld = mHeld && !(wb_ready || flush);
      if (modelLive() && !(BYP && wb_ready)) begin
         nextHeld = 1;
         mHLoad   = mPLoad;
         mHErr    = dmem_err;
         mHData   = mPLoad ? alignRef(dmem_rdata, mPAddr, mPBytes, mPSext) : 64'd0;
      end
      mHeld     = nextHeld;
      mPend     = req_sent;
      mPendDrop = flush;
      if (req_sent) begin
         mPLoad  = req_load;
         mPSext  = req_sext;
         mPAddr  = req_addr_lo;
         mPBytes = req_double ? 8 : req_word ? 4 : req_half ? 2 : 1;
      end
   endtask

   // One clock cycle: drive inputs after the edge, compare mid-cycle, then
   // step the model over the next edge.
   task automatic applyStimulus(input bit rstn, input bit fl, input bit rs, input bit ld,
                                input int bytes, input bit sx, input logic [2:0] addr,
                                input bit err, input logic [63:0] rd, input bit rdy);
      @(posedge g_clk);
      #1;
      g_resetn    = rstn;
      flush       = fl;
      req_sent    = rs;
      req_load    = ld;
      req_store   = !ld;
      req_double  = (bytes == 8);
      req_word    = (bytes == 4);
      req_half    = (bytes == 2);
      req_byte    = (bytes == 1);
      req_sext    = sx;
      req_addr_lo = addr;
      dmem_err    = err;
      dmem_rdata  = rd;
      wb_ready    = rdy;
      #4;
      checkOutput();
      modelStep();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] heldData;
      g_resetn = 0; flush = 0; req_sent = 0; req_load = 0; req_store = 0;
      req_double = 0; req_word = 0; req_half = 0; req_byte = 0; req_sext = 0;
      req_addr_lo = 0; dmem_err = 0; dmem_rdata = 0; wb_ready = 0;

      // Reset
      applyStimulus(0, 0, 0, 1, 8, 0, 0, 0, 64'd0, 0);
      applyStimulus(0, 0, 0, 1, 8, 0, 0, 0, 64'd0, 0);
      applyStimulus(1, 0, 0, 1, 8, 0, 0, 0, 64'd0, 0);
      checkValue("rst_valid", {63'd0, wb_valid}, 64'd0);
      checkValue("rst_rdata", wb_rdata, 64'd0);
      checkValue("rst_can_issue", {63'd0, rsp_can_issue}, 64'd1);

      // Byte load, sign-extended, offset 5
      applyStimulus(1, 0, 1, 1, 1, 1, 3'd5, 0, 64'd0, 1);
      applyStimulus(1, 0, 0, 1, 1, 0, 3'd0, 0, 64'h0000_8000_0000_0000, 0);
      checkValue("byte_wait_can_issue", {63'd0, rsp_can_issue}, 64'd0);
      applyStimulus(1, 0, 0, 1, 1, 0, 3'd0, 0, 64'd0, 0);
      checkValue("byte_valid", {63'd0, wb_valid}, 64'd1);
      checkValue("byte_rdata", wb_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      checkValue("byte_load", {63'd0, wb_load}, 64'd1);
      checkValue("byte_err", {63'd0, wb_err}, 64'd0);
      applyStimulus(1, 0, 0, 1, 1, 0, 3'd0, 0, 64'd0, 1);
      applyStimulus(1, 0, 0, 1, 1, 0, 3'd0, 0, 64'd0, 0);
      checkValue("byte_done_valid", {63'd0, wb_valid}, 64'd0);

      // Word load, zero-extended, offset 4, then backpressure
      applyStimulus(1, 0, 1, 1, 4, 0, 3'd4, 0, 64'd0, 0);
      applyStimulus(1, 0, 0, 1, 4, 0, 3'd0, 0, 64'h8765_4321_0000_0000, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 1, 4, 0, 3'd0, 0, {$urandom, $urandom}, 0);
         checkValue("bp_valid", {63'd0, wb_valid}, 64'd1);
         checkValue("bp_rdata", wb_rdata, 64'h0000_0000_8765_4321);
         checkValue("bp_can_issue", {63'd0, rsp_can_issue}, 64'd0);
      end
      applyStimulus(1, 0, 1, 1, 8, 0, 3'd0, 0, 64'd0, 1);
      checkValue("bp_release_can_issue", {63'd0, rsp_can_issue}, 64'd1);
      applyStimulus(1, 0, 0, 1, 8, 0, 3'd0, 0, 64'hDEAD_BEEF_0BAD_F00D, 0);
      checkValue("bp_next_wait_can_issue", {63'd0, rsp_can_issue}, 64'd0);
      checkValue("bp_next_wait_valid", {63'd0, wb_valid}, {63'd0, BYP});
      applyStimulus(1, 0, 0, 1, 8, 0, 3'd0, 0, 64'd0, 1);
      checkValue("bp_next_rdata", wb_rdata, 64'hDEAD_BEEF_0BAD_F00D);

      // Flush in the response cycle
      applyStimulus(1, 0, 1, 1, 4, 1, 3'd0, 0, 64'd0, 0);
      applyStimulus(1, 1, 0, 1, 4, 0, 3'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      checkValue("flush_wait_valid", {63'd0, wb_valid}, 64'd0);
      applyStimulus(1, 0, 0, 1, 4, 0, 3'd0, 0, 64'd0, 0);
      checkValue("flush_drop_can_issue", {63'd0, rsp_can_issue}, 64'd1);
      checkValue("flush_drop_valid", {63'd0, wb_valid}, 64'd0);
      applyStimulus(1, 0, 0, 1, 4, 0, 3'd0, 0, 64'd0, 0);
      checkValue("flush_idle_valid", {63'd0, wb_valid}, 64'd0);

      // Store with bus error
      applyStimulus(1, 0, 1, 0, 4, 0, 3'd0, 0, 64'd0, 0);
      applyStimulus(1, 0, 0, 0, 4, 0, 3'd0, 1, 64'h1234_5678_9ABC_DEF0, 0);
      applyStimulus(1, 0, 0, 0, 4, 0, 3'd0, 0, 64'd0, 0);
      checkValue("store_valid", {63'd0, wb_valid}, 64'd1);
      checkValue("store_load", {63'd0, wb_load}, 64'd0);
      checkValue("store_err", {63'd0, wb_err}, 64'd1);
      checkValue("store_rdata", wb_rdata, 64'd0);
      applyStimulus(1, 0, 0, 0, 4, 0, 3'd0, 0, 64'd0, 1);

      // Reset in the response cycle
      applyStimulus(1, 0, 1, 1, 2, 1, 3'd2, 0, 64'd0, 0);
      applyStimulus(0, 0, 0, 1, 2, 0, 3'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      applyStimulus(1, 0, 0, 1, 2, 0, 3'd0, 0, 64'd0, 0);
      checkValue("midrst_valid", {63'd0, wb_valid}, 64'd0);
      checkValue("midrst_rdata", wb_rdata, 64'd0);
      checkValue("midrst_load", {63'd0, wb_load}, 64'd0);
      checkValue("midrst_err", {63'd0, wb_err}, 64'd0);
      checkValue("midrst_can_issue", {63'd0, rsp_can_issue}, 64'd1);

`ifdef CORE_LSU_RSP_BYPASS_EN
      // Bypass: double load consumed in its response cycle
      applyStimulus(1, 0, 1, 1, 8, 0, 3'd0, 0, 64'd0, 1);
      applyStimulus(1, 0, 0, 1, 8, 0, 3'd0, 0, 64'h0123_4567_89AB_CDEF, 1);
      checkValue("byp_valid", {63'd0, wb_valid}, 64'd1);
      checkValue("byp_rdata", wb_rdata, 64'h0123_4567_89AB_CDEF);
      applyStimulus(1, 0, 0, 1, 8, 0, 3'd0, 0, 64'd0, 0);
      checkValue("byp_after_valid", {63'd0, wb_valid}, 64'd0);
      checkValue("byp_after_can_issue", {63'd0, rsp_can_issue}, 64'd1);
`endif

      // Randomized traffic; grants only where the model allows issue
      for (int c = 0; c < 3000; c++) begin
         bit          rstn, fl, rdy, rs, ld, sx, err;
         int          bytes;
         logic [2:0]  addr;
         logic [63:0] rd;
         rstn  = ($urandom_range(0, 99) != 0);
         fl    = ($urandom_range(0, 11) == 0);
         rdy   = ($urandom_range(0, 1) == 1);
         rs    = modelCanIssue(rdy) && ($urandom_range(0, 9) < 6);
         ld    = ($urandom_range(0, 3) != 0);
         sx    = ($urandom_range(0, 1) == 1);
         err   = ($urandom_range(0, 7) == 0);
         bytes = 1 << $urandom_range(0, 3);
         addr  = 3'($urandom_range(0, 7));
         rd    = {$urandom, $urandom};
         applyStimulus(rstn, fl, rs, ld, bytes, sx, addr, err, rd, rdy);
      end

      heldData = wb_rdata;
      $display("[TB] last wb_rdata %h", heldData);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_pipe_lsu_rsp.md
Name: core_pipe_lsu_rsp

Overview:
- Data-memory response stage directly downstream of the execute-stage LSU request logic.
- Captures the attributes of each granted load/store and collects the memory response one cycle later.
- Aligns, masks and sign-extends load data, and holds the result for the writeback stage under a valid/ready handshake.
- Tells the LSU when a new request may be issued; supports one outstanding transaction.

Parameters:
- XLEN, 64, register and result width.
- MEM_DATA_W, 64, memory data bus width. Must equal XLEN.

Ports:
- g_clk in 1: global clock.
- g_resetn in 1: synchronous reset, active-low.
- flush in 1: pipeline flush; discards any pending or held response.
- req_sent in 1: request accepted this cycle (dmem_req && dmem_gnt).
- req_load in 1: granted request is a load.
- req_store in 1: granted request is a store.
- req_double in 1: 8-byte access.
- req_word in 1: 4-byte access.
- req_half in 1: 2-byte access.
- req_byte in 1: 1-byte access.
- req_sext in 1: sign-extend load data.
- req_addr_lo in 3: addr[2:0] of the granted request.
- dmem_err in 1: memory response error; valid in the cycle after grant.
- dmem_rdata in MEM_DATA_W: memory read data; valid in the cycle after grant.
- rsp_can_issue out 1: the LSU may have a request granted this cycle.
- wb_valid out 1: response available to writeback.
- wb_ready in 1: writeback consumes the response.
- wb_load out 1: held response is a load.
- wb_err out 1: held response carries a bus error.
- wb_rdata out XLEN: aligned, extended load data; 0 for stores.

Behaviour:
- Memory protocol: fixed latency. dmem_rdata and dmem_err are valid exactly one cycle after req_sent and are sampled only then.
- States:
  - IDLE: no transaction.
  - WAIT: response arrives this cycle.
  - HOLD: result registered, wb_valid=1.
  - DROP: flushed transaction whose response must still be absorbed.
- Reset (g_resetn=0 at posedge): state=IDLE, wb_valid=0, wb_load=0, wb_err=0, wb_rdata=0. Reset mid-transaction abandons it; no output pulses afterwards.
- Attribute capture: on req_sent, register the size flags, sext, load/store and addr_lo. req_sent while rsp_can_issue=0 is a protocol violation; verification asserts it never occurs.
- Transitions:
  - IDLE: req_sent -> WAIT.
  - WAIT: -> HOLD. Register the aligned result and dmem_err. Set wb_load from the captured load flag.
  - HOLD with wb_ready: if req_sent -> WAIT, else -> IDLE.
  - HOLD without wb_ready: stay in HOLD. wb_* outputs stay stable.
  - DROP: -> IDLE, or -> WAIT if req_sent in the same cycle. The response is ignored.
- rsp_can_issue = (state==IDLE) || (state==HOLD && wb_ready) || state==DROP. It is deasserted in WAIT, so a new grant is never accepted while a response is arriving.
- Flush (highest priority):
  - In WAIT -> DROP; wb_valid never asserts for that transaction.
  - In HOLD -> IDLE; wb_valid drops next cycle.
  - In IDLE or DROP: no effect.
  - A req_sent coinciding with flush is also discarded. From IDLE or HOLD go to DROP; from WAIT stay WAIT->DROP.
- Alignment:
  - shifted = dmem_rdata >> (addr_lo*8).
  - byte: bits [7:0]. half: bits [15:0]. word: bits [31:0]. double: all 64 bits.
  - If req_sext, replicate the top bit of the selected field; otherwise zero-extend. double ignores sext.
  - Stores: wb_rdata=0, wb_err=dmem_err.
- wb_valid asserts only in HOLD, or in WAIT when the optional feature is enabled.

Optional Feature:
- Macro: CORE_LSU_RSP_BYPASS_EN.
- Defined:
  - In WAIT (not flushed), wb_valid=1 combinationally and wb_rdata/wb_err/wb_load come directly from the aligned dmem_rdata and dmem_err.
  - If wb_ready in WAIT, go to IDLE and skip HOLD. rsp_can_issue is still 0 in WAIT.
  - If not wb_ready, go to HOLD with the registered copy.
- Undefined: all wb_* outputs are registered, giving a minimum one cycle from WAIT to wb_valid.

Test Plan:
- Byte load with sign extension: req_byte, sext=1, addr_lo=5, dmem_rdata=0x0000_8000_0000_0000 next cycle -> wb_valid in HOLD, wb_rdata=0xFFFF_FFFF_FFFF_FF80, wb_load=1, wb_err=0.
- Word load with zero extension: req_word, sext=0, addr_lo=4, rdata=0x8765_4321_0000_0000 -> wb_rdata=0x0000_0000_8765_4321.
- Backpressure: hold wb_ready=0 for 3 cycles in HOLD -> wb_* stable, rsp_can_issue=0. Raise wb_ready together with req_sent -> next state WAIT with no bubble.
- Flush in WAIT: flush=1 in the response cycle, dmem_err=1 -> wb_valid never asserts; rsp_can_issue=1 in the DROP cycle.
- Store error: req_store, dmem_err=1 -> wb_valid=1, wb_load=0, wb_err=1, wb_rdata=0.
- Reset mid-op: g_resetn=0 in WAIT -> next cycle state IDLE, all outputs 0. With CORE_LSU_RSP_BYPASS_EN defined, a double load with wb_ready=1 gives wb_valid in the WAIT cycle, then IDLE.
